sram_arbiter: RTL
=================

# sram_arbiter

Two-port arbiter and sequencer in front of the SRAM controller. Shares one SRAM bank between the instruction-fetch port (read-only) and the data port (read/write). Converts each requester's level req/ack handshake into the controller's one-cycle active-low strobe plus `valid` close-out. Captures read data. Sits between the CPU pipeline and the SRAM controller.

## Interface

Parameters:
- `WAIT_CYCLES`, 2: cycles spent in WAIT per access (SRAM access time); legal range 1..15.
- `DATA_PRIORITY`, 1: 1 = data port wins every conflict; 0 = round-robin between the two ports.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous active-high reset.
- `if_req_i`  in  1  fetch request; held until `if_ack_o`.
- `if_addr_i`  in  32  fetch address; stable while `if_req_i`.
- `if_ack_o`  out  1  one-cycle completion pulse.
- `if_rdata_o`  out  32  fetch data; valid in the ack cycle, held until the next fetch ack.
- `d_req_i`  in  1  data request; held until `d_ack_o`.
- `d_we_i`  in  1  1 = write, 0 = read.
- `d_be_n_i`  in  4  byte enables, active-low.
- `d_addr_i`  in  32  data address.
- `d_wdata_i`  in  32  write data.
- `d_ack_o`  out  1  one-cycle completion pulse.
- `d_rdata_o`  out  32  load data; valid in the ack cycle, held until the next data read ack.
- `mem_re_n_o`  out  1  read strobe to the controller, active-low.
- `mem_we_n_o`  out  1  write strobe to the controller, active-low.
- `mem_be_n_o`  out  4  byte enables to the controller.
- `mem_addr_o`  out  32  address to the controller.
- `mem_wdata_o`  out  32  write data to the controller.
- `mem_rdata_i`  in  32  read data from the controller.
- `mem_busy_i`  in  1  controller accepted the strobe.
- `mem_valid_o`  out  1  close-out pulse; returns the controller to idle.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - No request: stay in IDLE.
  - One or both requests: pick a winner (see arbitration).
  - Latch the winner's addr, wdata and be_n onto `mem_*`. Fetch uses be_n = 4'b0000 and is always a read.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle)
  - Assert `mem_re_n_o` or `mem_we_n_o` low.
  - Load the counter with `WAIT_CYCLES`.
  - Go to WAIT.
- WAIT
  - Both strobes high.
  - Decrement the counter each cycle.
  - Go to DONE when the counter reaches 1.
  - `mem_busy_i` is ignored for sequencing; it is checked only by assertion.
- DONE (1 cycle)
  - Assert `mem_valid_o`.
  - Pulse the owner's ack.
  - For a read, copy `mem_rdata_i` into the owner's rdata register.
  - Go to IDLE.
- Arbitration
  - `DATA_PRIORITY`=1: data always wins a conflict.
  - `DATA_PRIORITY`=0: a last-grant bit selects the other port on a conflict. The bit updates on every grant. Reset value of the bit = fetch, so data wins the first conflict.
- Grant is decided only in IDLE. A request that appears mid-transaction waits; the owner never changes mid-transaction.
- A requester that drops req before its ack has undefined behaviour; the assertion checks flag it.
- Write: `d_rdata_o` is unchanged.

## Timing

- Reset values:
  - FSM state = IDLE.
  - `mem_re_n_o` = `mem_we_n_o` = 1.
  - `mem_be_n_o` = 4'b1111.
  - `mem_addr_o` = 0; `mem_wdata_o` = 0.
  - `mem_valid_o` = 0; both acks = 0.
  - Both rdata outputs = 0.
- All outputs are registered.
- Latency: req sampled in cycle 0 → ISSUE in cycle 1 → WAIT in cycles 2..1+`WAIT_CYCLES` → DONE/ack in cycle 2+`WAIT_CYCLES`. With the default this is the ack in cycle 4.
- Throughput: a new grant is possible in the cycle after DONE, so one access per `WAIT_CYCLES`+3 cycles.
- Reset asserted in any state: the next edge forces the reset values. No ack is issued, and a strobe in progress is dropped.
- Requester rule: req must be low in the cycle after its ack unless a new access is intended. A req still high after ack is a new request.

## Structure

- `common.vh` holds:
  - the state encodings (`ARB_IDLE`..`ARB_DONE`, 2 bits);
  - the fetch byte-enable constant 4'b0000;
  - the grant IDs (`GNT_IF`=0, `GNT_D`=1).
- One sub-module, `arb_rr2`: a combinational 2-way grant with a registered last-grant bit and a fixed-priority override input.
- The counter width is 4 bits.

## Test plan

- Single fetch, addr 0x8000_0010, controller returns 0x1234_5678. Required response:
  - `mem_re_n_o` low only in cycle 1;
  - `mem_valid_o` and `if_ack_o` in cycle 4;
  - `if_rdata_o` = 0x1234_5678.
- Data write, addr 0x8040_0000, wdata 0xDEAD_BEEF, be_n 4'b1100. Required response:
  - `mem_we_n_o` low for one cycle with matching addr/data/be_n;
  - `d_ack_o` in cycle 4;
  - `d_rdata_o` unchanged.
- Both ports request in the same cycle with `DATA_PRIORITY`=1. Required response:
  - data is served first, ack in cycle 4;
  - fetch is granted in cycle 5, ack in cycle 9.
- `DATA_PRIORITY`=0, both ports requesting continuously for 4 transactions. Required response: grants alternate D, IF, D, IF; no port is starved.
- Reset asserted in WAIT. Required response:
  - next cycle: all outputs at reset values, no ack;
  - a fresh request afterwards completes normally.
- `WAIT_CYCLES`=1 and `WAIT_CYCLES`=15. Required response: ack in cycle 3 and cycle 17 respectively.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: FSM encodings, fetch byte enables
// and grant identifiers.
package sram_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_DONE  = 2'd3;

    // Instruction fetch always reads the full word.
    localparam logic [3:0] FETCH_BE_N = 4'b0000;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/sram_arbiter_arb_rr2.sv
// Two-way grant: combinational pick between fetch and data, with a registered
// last-grant bit for round-robin and an override that makes data always win.
module sram_arbiter_arb_rr2
    import sram_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_if,
    input  logic req_d,
    input  logic fixed_d,
    input  logic grant_en,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_gnt_reg;

    // On a conflict data wins when forced, or when fetch had the previous grant.
    always_comb begin
        gnt_valid = req_if | req_d;
        gnt_id    = GNT_IF;
        if (req_d && (!req_if || fixed_d || (last_gnt_reg == GNT_IF)))
            gnt_id = GNT_D;
    end

    // Remember who won each committed grant; starts at fetch so data wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            last_gnt_reg <= GNT_IF;
        else if (grant_en && gnt_valid)
            last_gnt_reg <= gnt_id;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between the fetch port and the data port.
// Each access runs IDLE -> ISSUE (strobe) -> WAIT (fixed access time) ->
// DONE (close-out + ack). All outputs come straight from registers.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES   = 2,
    parameter int DATA_PRIORITY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_n_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_re_n_o,
    output logic        mem_we_n_o,
    output logic [3:0]  mem_be_n_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_busy_i,
    output logic        mem_valid_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic       FIXED_D   = (DATA_PRIORITY != 0);

    logic [1:0] state_reg;
    logic [3:0] cnt_reg;
    logic       owner_reg;
    logic       is_write_reg;
    logic       gnt_valid;
    logic       gnt_id;

    sram_arbiter_arb_rr2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_if    (if_req_i),
        .req_d     (d_req_i),
        .fixed_d   (FIXED_D),
        .grant_en  (state_reg == ARB_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Sequencer: strobes and pulses default inactive and are set one cycle
    // ahead so they appear registered in ISSUE and DONE respectively.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ARB_IDLE;
            cnt_reg      <= 4'd0;
            owner_reg    <= GNT_IF;
            is_write_reg <= 1'b0;
            mem_re_n_o   <= 1'b1;
            mem_we_n_o   <= 1'b1;
            mem_be_n_o   <= 4'b1111;
            mem_addr_o   <= 32'd0;
            mem_wdata_o  <= 32'd0;
            mem_valid_o  <= 1'b0;
            if_ack_o     <= 1'b0;
            d_ack_o      <= 1'b0;
            if_rdata_o   <= 32'd0;
            d_rdata_o    <= 32'd0;
        end else begin
            mem_re_n_o  <= 1'b1;
            mem_we_n_o  <= 1'b1;
            mem_valid_o <= 1'b0;
            if_ack_o    <= 1'b0;
            d_ack_o     <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        owner_reg <= gnt_id;
                        state_reg <= ARB_ISSUE;
                        if (gnt_id == GNT_D) begin
                            mem_addr_o   <= d_addr_i;
                            mem_wdata_o  <= d_wdata_i;
                            mem_be_n_o   <= d_be_n_i;
                            is_write_reg <= d_we_i;
                            mem_re_n_o   <= d_we_i;
                            mem_we_n_o   <= !d_we_i;
                        end else begin
                            mem_addr_o   <= if_addr_i;
                            mem_be_n_o   <= FETCH_BE_N;
                            is_write_reg <= 1'b0;
                            mem_re_n_o   <= 1'b0;
                        end
                    end
                end
                ARB_ISSUE: begin
                    cnt_reg   <= WAIT_LOAD;
                    state_reg <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg   <= ARB_DONE;
                        mem_valid_o <= 1'b1;
                        if (owner_reg == GNT_D) begin
                            d_ack_o <= 1'b1;
                            if (!is_write_reg)
                                d_rdata_o <= mem_rdata_i;
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                ARB_DONE: begin
                    state_reg <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    // The controller must report busy throughout the access window.
    a_busy_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_reg == ARB_WAIT) |-> mem_busy_i);

    // The owner may not withdraw its request before it has been acknowledged.
    a_owner_holds_req: assert property (@(posedge clk_i) disable iff (rst_i)
        ((state_reg == ARB_ISSUE) || (state_reg == ARB_WAIT)) |->
            ((owner_reg == GNT_D) ? d_req_i : if_req_i));

endmodule
